// File: rtl/bp_be_dcache_lce_req_mshr_pkg.sv
// Shared types for the multi-outstanding dcache LCE request handler.
// Also holds the small helpers used for sizing and lowest-index selection.
package bp_be_dcache_lce_req_mshr_pkg;

  typedef enum logic [1:0] {
    e_miss_load, e_miss_store, e_miss_lr, e_miss_uc_load
  } bp_be_dcache_miss_type_e;

  typedef enum logic [2:0] {
    e_FREE, e_SEND_REQ, e_SLEEP, e_SEND_TR_ACK, e_SEND_COH_ACK
  } bp_be_dcache_mshr_state_e;

  typedef enum logic {e_lce_req_type_rd, e_lce_req_type_wr} bp_lce_cce_req_type_e;
  typedef enum logic {e_lce_req_cacheable, e_lce_req_non_cacheable} bp_lce_cce_req_nc_e;
  typedef enum logic {e_lce_req_excl, e_lce_req_non_excl} bp_lce_cce_req_excl_e;

  typedef enum logic [1:0] {
    e_lce_cce_sync_ack, e_lce_cce_inv_ack, e_lce_cce_tr_ack, e_lce_cce_coh_ack
  } bp_lce_cce_resp_type_e;

  function automatic int unsigned safe_clog2(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit, 0 when none is set.
  function automatic int unsigned lowest_set(logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bp_be_dcache_lce_req_mshr_entry.sv
// One miss-status entry: state machine plus the fields captured at allocation.
module bp_be_dcache_lce_req_mshr_entry
  import bp_be_dcache_lce_req_mshr_pkg::*;
#(
  parameter int unsigned paddr_width_p  = 22,
  parameter int unsigned way_id_width_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      alloc_i,
  input  logic [paddr_width_p-1:0]  addr_i,
  input  logic [1:0]                miss_type_i,
  input  logic [1:0]                size_op_i,
  input  logic [way_id_width_p-1:0] lru_way_i,
  input  logic                      lru_dirty_i,
  input  logic                      req_sent_i,
  input  logic                      resp_yumi_i,
  input  logic                      tr_data_i,
  input  logic                      cce_data_i,
  input  logic                      uc_data_i,
  input  logic                      set_tag_i,
  input  logic                      set_tag_wakeup_i,
  output logic [2:0]                state_o,
  output logic [paddr_width_p-1:0]  addr_o,
  output logic [1:0]                miss_type_o,
  output logic [1:0]                size_op_o,
  output logic [way_id_width_p-1:0] lru_way_o,
  output logic                      lru_dirty_o
);

  bp_be_dcache_mshr_state_e state_q;
  logic                      tr_q, cce_q, st_q;
  logic                      tr_f, cce_f, st_f;
  logic [paddr_width_p-1:0]  addr_q;
  logic [1:0]                miss_type_q, size_op_q;
  logic [way_id_width_p-1:0] lru_way_q;
  logic                      lru_dirty_q;

  // Completion flags as seen this cycle, including the event arriving now.
  assign tr_f  = tr_q | tr_data_i;
  assign cce_f = cce_q | cce_data_i;
  assign st_f  = st_q | set_tag_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_FREE;
      tr_q        <= 1'b0;
      cce_q       <= 1'b0;
      st_q        <= 1'b0;
      addr_q      <= '0;
      miss_type_q <= '0;
      size_op_q   <= '0;
      lru_way_q   <= '0;
      lru_dirty_q <= 1'b0;
    end else begin
      case (state_q)
        e_FREE: if (alloc_i) begin
          addr_q      <= addr_i;
          miss_type_q <= miss_type_i;
          size_op_q   <= size_op_i;
          lru_way_q   <= lru_way_i;
          lru_dirty_q <= lru_dirty_i;
          tr_q        <= 1'b0;
          cce_q       <= 1'b0;
          st_q        <= 1'b0;
          state_q     <= e_SEND_REQ;
        end
        e_SEND_REQ: if (req_sent_i) state_q <= e_SLEEP;
        e_SLEEP: begin
          tr_q  <= tr_f;
          cce_q <= cce_f;
          st_q  <= st_f;
          if (set_tag_wakeup_i)  state_q <= e_SEND_COH_ACK;
          else if (uc_data_i)    state_q <= e_FREE;
          else if (st_f && tr_f) state_q <= e_SEND_TR_ACK;
          else if (st_f && cce_f) state_q <= e_SEND_COH_ACK;
        end
        e_SEND_TR_ACK, e_SEND_COH_ACK: if (resp_yumi_i) state_q <= e_FREE;
        default: state_q <= e_FREE;
      endcase
    end
  end

  assign state_o     = state_q;
  assign addr_o      = addr_q;
  assign miss_type_o = miss_type_q;
  assign size_op_o   = size_op_q;
  assign lru_way_o   = lru_way_q;
  assign lru_dirty_o = lru_dirty_q;

endmodule

// File: rtl/bp_be_dcache_lce_req_mshr.sv
// Multi-outstanding LCE request handler: allocates miss entries, arbitrates their
// requests onto the LCE request channel and their acks onto the response channel.
module bp_be_dcache_lce_req_mshr
  import bp_be_dcache_lce_req_mshr_pkg::*;
#(
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned paddr_width_p = 22,
  parameter int unsigned num_cce_p     = 2,
  parameter int unsigned num_lce_p     = 2,
  parameter int unsigned ways_p        = 8,
  parameter int unsigned mshr_els_p    = 2,
  localparam int unsigned IdWidth      = safe_clog2(mshr_els_p),
  localparam int unsigned LceIdWidth   = safe_clog2(num_lce_p),
  localparam int unsigned CceIdWidth   = safe_clog2(num_cce_p),
  localparam int unsigned WayIdWidth   = safe_clog2(ways_p),
  localparam int unsigned ReqWidth     = CceIdWidth + LceIdWidth + 2 + paddr_width_p
                                         + WayIdWidth + 4 + data_width_p,
  localparam int unsigned RespWidth    = CceIdWidth + LceIdWidth + 2 + paddr_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [LceIdWidth-1:0]                 lce_id_i,
  input  logic                                  miss_v_i,
  input  logic [1:0]                            miss_type_i,
  input  logic [paddr_width_p-1:0]              miss_addr_i,
  input  logic [WayIdWidth-1:0]                 lru_way_i,
  input  logic [ways_p-1:0]                     dirty_i,
  input  logic [1:0]                            size_op_i,
  output logic                                  miss_ready_o,
  output logic [IdWidth-1:0]                    miss_id_o,
  input  logic                                  uc_store_v_i,
  input  logic [data_width_p-1:0]               store_data_i,
  output logic                                  uc_store_ready_o,
  output logic [mshr_els_p-1:0]                 entry_v_o,
  output logic [mshr_els_p*paddr_width_p-1:0]   entry_addr_o,
  input  logic                                  tr_data_received_i,
  input  logic                                  cce_data_received_i,
  input  logic                                  uc_data_received_i,
  input  logic                                  set_tag_received_i,
  input  logic                                  set_tag_wakeup_received_i,
  input  logic [IdWidth-1:0]                    received_id_i,
  output logic [ReqWidth-1:0]                   lce_req_o,
  output logic                                  lce_req_v_o,
  input  logic                                  lce_req_ready_i,
  output logic [RespWidth-1:0]                  lce_resp_o,
  output logic                                  lce_resp_v_o,
  input  logic                                  lce_resp_yumi_i,
  input  logic                                  credits_full_i
);

  localparam int unsigned BlockOffset = $clog2(ways_p * data_width_p / 8);

  logic [mshr_els_p-1:0][2:0]               state;
  logic [mshr_els_p-1:0][paddr_width_p-1:0] addr;
  logic [mshr_els_p-1:0][1:0]               mtype, size_op;
  logic [mshr_els_p-1:0][WayIdWidth-1:0]    lru_way;
  logic [mshr_els_p-1:0]                    lru_dirty, free_vec, req_vec, ack_vec;
  logic                                     conflict, req_any, uc_v, lock_v_q;
  logic [IdWidth-1:0]                       free_id, grant_id, ack_id, lock_id_q;

  function automatic logic [CceIdWidth-1:0] dst_of(logic [paddr_width_p-1:0] a);
    return (num_cce_p == 1) ? '0 : a[BlockOffset +: CceIdWidth];
  endfunction

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < mshr_els_p; i++) begin
      free_vec[i] = (state[i] == e_FREE);
      req_vec[i]  = (state[i] == e_SEND_REQ);
      ack_vec[i]  = (state[i] == e_SEND_TR_ACK) || (state[i] == e_SEND_COH_ACK);
      conflict   |= !free_vec[i] && (addr[i][paddr_width_p-1:BlockOffset]
                                     == miss_addr_i[paddr_width_p-1:BlockOffset]);
    end
  end

  assign free_id      = IdWidth'(lowest_set(32'(free_vec)));
  assign ack_id       = IdWidth'(lowest_set(32'(ack_vec)));
  assign req_any      = |req_vec;
  // A request left waiting for ready keeps the grant until it is accepted.
  assign grant_id     = lock_v_q ? lock_id_q : IdWidth'(lowest_set(32'(req_vec)));
  assign miss_ready_o = miss_v_i && (|free_vec) && !conflict;
  assign miss_id_o    = free_id;
  assign entry_v_o    = ~free_vec;
  assign entry_addr_o = addr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_v_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_v_q  <= req_any && !lce_req_ready_i;
      lock_id_q <= grant_id;
    end
  end

  for (genvar i = 0; i < mshr_els_p; i++) begin : g_entry
    logic hit;
    assign hit = (received_id_i == IdWidth'(i));
    bp_be_dcache_lce_req_mshr_entry #(
      .paddr_width_p (paddr_width_p),
      .way_id_width_p(WayIdWidth)
    ) u_entry (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .alloc_i         (miss_ready_o && (free_id == IdWidth'(i))),
      .addr_i          (miss_addr_i),
      .miss_type_i     (miss_type_i),
      .size_op_i       (size_op_i),
      .lru_way_i       (lru_way_i),
      .lru_dirty_i     (dirty_i[lru_way_i]),
      .req_sent_i      (req_any && lce_req_ready_i && (grant_id == IdWidth'(i))),
      .resp_yumi_i     (lce_resp_yumi_i && (|ack_vec) && (ack_id == IdWidth'(i))),
      .tr_data_i       (hit && tr_data_received_i),
      .cce_data_i      (hit && cce_data_received_i),
      .uc_data_i       (hit && uc_data_received_i),
      .set_tag_i       (hit && set_tag_received_i),
      .set_tag_wakeup_i(hit && set_tag_wakeup_received_i),
      .state_o         (state[i]),
      .addr_o          (addr[i]),
      .miss_type_o     (mtype[i]),
      .size_op_o       (size_op[i]),
      .lru_way_o       (lru_way[i]),
      .lru_dirty_o     (lru_dirty[i])
    );
  end

  assign uc_v             = !req_any && uc_store_v_i && !credits_full_i;
  assign lce_req_v_o      = req_any || uc_v;
  assign uc_store_ready_o = uc_v && lce_req_ready_i;

  logic                     r_msg, r_nc, r_dirty, r_uc;
  logic [paddr_width_p-1:0] r_addr;
  logic [WayIdWidth-1:0]    r_way;
  logic [1:0]               r_size;
  logic [data_width_p-1:0]  r_data;

  always_comb begin
    r_uc    = (mtype[grant_id] == e_miss_uc_load);
    r_msg   = e_lce_req_type_wr;
    r_nc    = e_lce_req_non_cacheable;
    r_addr  = miss_addr_i;
    r_way   = '0;
    r_dirty = 1'b0;
    r_size  = size_op_i;
    r_data  = store_data_i;
    if (req_any) begin
      r_msg  = (mtype[grant_id] == e_miss_store || mtype[grant_id] == e_miss_lr)
               ? e_lce_req_type_wr : e_lce_req_type_rd;
      r_nc   = r_uc ? e_lce_req_non_cacheable : e_lce_req_cacheable;
      r_addr = addr[grant_id];
      r_data = '0;
      if (r_uc) begin
        r_size = size_op[grant_id];
      end else begin
        r_size  = '0;
        r_way   = lru_way[grant_id];
        r_dirty = lru_dirty[grant_id];
      end
    end
  end

  assign lce_req_o = {dst_of(r_addr), lce_id_i, r_msg, e_lce_req_excl, r_addr, r_way, r_dirty,
                      r_nc, r_size, r_data};

  assign lce_resp_v_o = |ack_vec;
  assign lce_resp_o   = {dst_of(addr[ack_id]), lce_id_i,
                         (state[ack_id] == e_SEND_TR_ACK) ? e_lce_cce_tr_ack : e_lce_cce_coh_ack,
                         addr[ack_id]};

  // Completion events are only meaningful for a sleeping entry.
  assert property (@(posedge clk_i) disable iff (reset_i)
    (tr_data_received_i || cce_data_received_i || uc_data_received_i || set_tag_received_i
     || set_tag_wakeup_received_i) |-> (state[received_id_i] == e_SLEEP))
    else $error("completion event to entry %0d which is not sleeping", received_id_i);

endmodule

// File: tb/tb_bp_be_dcache_lce_req_mshr.sv
// Directed bench for the multi-outstanding dcache LCE request handler.
module tb_bp_be_dcache_lce_req_mshr;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        lce_id_i;
  logic        miss_v_i;
  logic [1:0]  miss_type_i;
  logic [21:0] miss_addr_i;
  logic [2:0]  lru_way_i;
  logic [7:0]  dirty_i;
  logic [1:0]  size_op_i;
  logic        miss_ready_o;
  logic        miss_id_o;
  logic        uc_store_v_i;
  logic [63:0] store_data_i;
  logic        uc_store_ready_o;
  logic [1:0]  entry_v_o;
  logic [43:0] entry_addr_o;
  logic        tr_i, cce_i, uc_i, st_i, stw_i;
  logic        received_id_i;
  logic [96:0] lce_req_o;
  logic        lce_req_v_o;
  logic        lce_req_ready_i;
  logic [25:0] lce_resp_o;
  logic        lce_resp_v_o;
  logic        lce_resp_yumi_i;
  logic        credits_full_i;

  typedef struct packed {
    logic dst; logic src; logic msg; logic nexcl; logic [21:0] addr;
    logic [2:0] way; logic dirty; logic nc; logic [1:0] size; logic [63:0] data;
  } req_t;
  typedef struct packed {logic dst; logic src; logic [1:0] msg; logic [21:0] addr;} resp_t;

  req_t  rq;
  resp_t rs;
  assign rq = req_t'(lce_req_o);
  assign rs = resp_t'(lce_resp_o);

  int n_vec = 0;
  int n_err = 0;

  bp_be_dcache_lce_req_mshr dut (
    .clk_i                    (clk_i),
    .reset_i                  (reset_i),
    .lce_id_i                 (lce_id_i),
    .miss_v_i                 (miss_v_i),
    .miss_type_i              (miss_type_i),
    .miss_addr_i              (miss_addr_i),
    .lru_way_i                (lru_way_i),
    .dirty_i                  (dirty_i),
    .size_op_i                (size_op_i),
    .miss_ready_o             (miss_ready_o),
    .miss_id_o                (miss_id_o),
    .uc_store_v_i             (uc_store_v_i),
    .store_data_i             (store_data_i),
    .uc_store_ready_o         (uc_store_ready_o),
    .entry_v_o                (entry_v_o),
    .entry_addr_o             (entry_addr_o),
    .tr_data_received_i       (tr_i),
    .cce_data_received_i      (cce_i),
    .uc_data_received_i       (uc_i),
    .set_tag_received_i       (st_i),
    .set_tag_wakeup_received_i(stw_i),
    .received_id_i            (received_id_i),
    .lce_req_o                (lce_req_o),
    .lce_req_v_o              (lce_req_v_o),
    .lce_req_ready_i          (lce_req_ready_i),
    .lce_resp_o               (lce_resp_o),
    .lce_resp_v_o             (lce_resp_v_o),
    .lce_resp_yumi_i          (lce_resp_yumi_i),
    .credits_full_i           (credits_full_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [21:0] a, input logic [2:0] w,
                       input logic [7:0] d, input logic [1:0] s);
    miss_v_i = 1'b1; miss_type_i = t; miss_addr_i = a; lru_way_i = w; dirty_i = d;
    size_op_i = s;
    #1;
  endtask

  task automatic event_to(input logic id, input logic tr, input logic cce, input logic uc,
                          input logic st, input logic stw);
    received_id_i = id; tr_i = tr; cce_i = cce; uc_i = uc; st_i = st; stw_i = stw;
    step();
    {tr_i, cce_i, uc_i, st_i, stw_i} = '0;
    #1;
  endtask

  task automatic send_one();
    lce_req_ready_i = 1'b1;
    step();
    lce_req_ready_i = 1'b0;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; lce_id_i = 1'b1; miss_v_i = 1'b0; miss_type_i = '0; miss_addr_i = '0;
    lru_way_i = '0; dirty_i = '0; size_op_i = '0; uc_store_v_i = 1'b0; store_data_i = '0;
    {tr_i, cce_i, uc_i, st_i, stw_i} = '0; received_id_i = 1'b0; lce_req_ready_i = 1'b0;
    lce_resp_yumi_i = 1'b0; credits_full_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    #1;
    check_eq("rst_entry_v", entry_v_o, 0);
    check_eq("rst_entry_addr", entry_addr_o, 0);
    check_eq("rst_req_v", lce_req_v_o, 0);
    check_eq("rst_resp_v", lce_resp_v_o, 0);
    check_eq("rst_miss_ready", miss_ready_o, 0);
    check_eq("rst_uc_ready", uc_store_ready_o, 0);
    check_eq("rst_miss_id", miss_id_o, 0);

    // Single cached load miss
    alloc(2'd0, 22'h8040, 3'd3, 8'h08, 2'd0);
    check_eq("t1_miss_ready", miss_ready_o, 1);
    check_eq("t1_miss_id", miss_id_o, 0);
    check_eq("t1_no_comb_req", lce_req_v_o, 0);
    step();
    miss_v_i = 1'b0; dirty_i = '0; lru_way_i = '0;
    #1;
    check_eq("t1_req_v", lce_req_v_o, 1);
    check_eq("t1_req_addr", rq.addr, 22'h8040);
    check_eq("t1_req_msg", rq.msg, 0);
    check_eq("t1_req_nc", rq.nc, 0);
    check_eq("t1_req_way", rq.way, 3);
    check_eq("t1_req_dirty", rq.dirty, 1);
    check_eq("t1_req_dst", rq.dst, 1);
    check_eq("t1_req_src", rq.src, 1);
    check_eq("t1_req_nexcl", rq.nexcl, 0);
    send_one();
    check_eq("t1_req_done", lce_req_v_o, 0);
    check_eq("t1_entry_busy", entry_v_o, 2'b01);
    event_to(1'b0, 0, 0, 0, 1, 0);
    check_eq("t1_no_ack_tag_only", lce_resp_v_o, 0);
    event_to(1'b0, 0, 1, 0, 0, 0);
    check_eq("t1_ack_v", lce_resp_v_o, 1);
    check_eq("t1_ack_msg", rs.msg, 3);
    check_eq("t1_ack_addr", rs.addr, 22'h8040);
    check_eq("t1_ack_dst", rs.dst, 1);
    lce_resp_yumi_i = 1'b1;
    step();
    lce_resp_yumi_i = 1'b0;
    #1;
    check_eq("t1_freed", entry_v_o, 0);
    check_eq("t1_ack_gone", lce_resp_v_o, 0);

    // Two outstanding misses, ready held low, grant held across a new allocation
    alloc(2'd0, 22'h1000, 3'd0, 8'h00, 2'd0);
    check_eq("t2_id0", miss_id_o, 0);
    step();
    alloc(2'd0, 22'h2000, 3'd1, 8'h00, 2'd0);
    check_eq("t2_ready1", miss_ready_o, 1);
    check_eq("t2_id1", miss_id_o, 1);
    check_eq("t2_req_a", rq.addr, 22'h1000);
    step();
    alloc(2'd0, 22'h3000, 3'd0, 8'h00, 2'd0);
    check_eq("t2_full", miss_ready_o, 0);
    check_eq("t2_req_b", rq.addr, 22'h1000);
    step();
    miss_v_i = 1'b0;
    #1;
    check_eq("t2_req_c", rq.addr, 22'h1000);
    send_one();
    check_eq("t2_req_e1", rq.addr, 22'h2000);
    check_eq("t2_req_e1_v", lce_req_v_o, 1);
    step();
    event_to(1'b0, 0, 0, 1, 0, 0);
    alloc(2'd0, 22'h5000, 3'd0, 8'h00, 2'd0);
    check_eq("t2_realloc_ready", miss_ready_o, 1);
    check_eq("t2_realloc_id", miss_id_o, 0);
    step();
    miss_v_i = 1'b0;
    #1;
    check_eq("t2_lock_held", rq.addr, 22'h2000);
    lce_req_ready_i = 1'b1;
    step();
    check_eq("t2_req_e0", rq.addr, 22'h5000);
    step();
    lce_req_ready_i = 1'b0;
    event_to(1'b1, 1, 0, 0, 0, 0);
    check_eq("t2_no_ack_tr_only", lce_resp_v_o, 0);
    event_to(1'b1, 0, 0, 0, 1, 0);
    check_eq("t2_ack_v", lce_resp_v_o, 1);
    check_eq("t2_ack_msg", rs.msg, 2);
    check_eq("t2_ack_addr", rs.addr, 22'h2000);
    lce_resp_yumi_i = 1'b1;
    step();
    lce_resp_yumi_i = 1'b0;
    event_to(1'b0, 0, 0, 1, 0, 0);
    check_eq("t2_all_free", entry_v_o, 0);

    // Same-block conflict
    alloc(2'd1, 22'h1000, 3'd0, 8'h00, 2'd0);
    step();
    alloc(2'd1, 22'h1008, 3'd0, 8'h00, 2'd0);
    check_eq("t3_store_msg", rq.msg, 1);
    check_eq("t3_conflict", miss_ready_o, 0);
    miss_v_i = 1'b0;
    send_one();
    alloc(2'd1, 22'h1008, 3'd0, 8'h00, 2'd0);
    uc_i = 1'b1; received_id_i = 1'b0;
    #1;
    check_eq("t3_not_same_cycle", miss_ready_o, 0);
    step();
    uc_i = 1'b0;
    #1;
    check_eq("t3_next_cycle", miss_ready_o, 1);
    check_eq("t3_next_id", miss_id_o, 0);
    step();
    miss_v_i = 1'b0;
    #1;

    // Uncached store behind credits and behind a pending entry
    send_one();
    uc_store_v_i = 1'b1; credits_full_i = 1'b1; miss_addr_i = 22'h0abc; size_op_i = 2'd3;
    store_data_i = 64'hdead_beef_cafe_f00d; lce_req_ready_i = 1'b1;
    #1;
    check_eq("t4_credit_block_v", lce_req_v_o, 0);
    check_eq("t4_credit_block_rdy", uc_store_ready_o, 0);
    lce_req_ready_i = 1'b0; credits_full_i = 1'b0;
    alloc(2'd0, 22'h4000, 3'd2, 8'h00, 2'd3);
    check_eq("t4_st_v", lce_req_v_o, 1);
    check_eq("t4_st_nc", rq.nc, 1);
    check_eq("t4_alloc_id", miss_id_o, 1);
    step();
    miss_v_i = 1'b0; miss_addr_i = 22'h0abc; lce_req_ready_i = 1'b1;
    #1;
    check_eq("t4_entry_first", rq.addr, 22'h4000);
    check_eq("t4_entry_size0", rq.size, 0);
    check_eq("t4_store_waits", uc_store_ready_o, 0);
    step();
    check_eq("t4_st_addr", rq.addr, 22'h0abc);
    check_eq("t4_st_data", rq.data, 64'hdead_beef_cafe_f00d);
    check_eq("t4_st_size", rq.size, 3);
    check_eq("t4_st_msg", rq.msg, 1);
    check_eq("t4_st_ready", uc_store_ready_o, 1);
    step();
    uc_store_v_i = 1'b0; lce_req_ready_i = 1'b0;
    event_to(1'b0, 0, 0, 1, 0, 0);
    event_to(1'b1, 0, 0, 1, 0, 0);
    check_eq("t4_all_free", entry_v_o, 0);

    // LR and uncached load
    alloc(2'd2, 22'h6000, 3'd2, 8'h04, 2'd0);
    step();
    miss_v_i = 1'b0;
    #1;
    check_eq("t5_lr_msg", rq.msg, 1);
    check_eq("t5_lr_nc", rq.nc, 0);
    check_eq("t5_lr_dirty", rq.dirty, 1);
    send_one();
    alloc(2'd3, 22'h7010, 3'd5, 8'hff, 2'd2);
    check_eq("t5_uc_id", miss_id_o, 1);
    step();
    miss_v_i = 1'b0;
    #1;
    check_eq("t5_uc_nc", rq.nc, 1);
    check_eq("t5_uc_msg", rq.msg, 0);
    check_eq("t5_uc_size", rq.size, 2);
    check_eq("t5_uc_dirty", rq.dirty, 0);
    check_eq("t5_uc_addr", rq.addr, 22'h7010);
    send_one();
    event_to(1'b1, 0, 0, 1, 0, 0);
    check_eq("t5_uc_freed", entry_v_o, 2'b01);
    check_eq("t5_uc_no_resp", lce_resp_v_o, 0);
    event_to(1'b0, 0, 0, 0, 0, 1);
    check_eq("t5_wake_ack", lce_resp_v_o, 1);
    check_eq("t5_wake_msg", rs.msg, 3);
    check_eq("t5_wake_addr", rs.addr, 22'h6000);
    lce_resp_yumi_i = 1'b1;
    step();
    lce_resp_yumi_i = 1'b0;
    #1;
    check_eq("t5_all_free", entry_v_o, 0);

    // Reset while an entry sleeps
    alloc(2'd0, 22'h8040, 3'd1, 8'h00, 2'd0);
    step();
    miss_v_i = 1'b0;
    send_one();
    event_to(1'b0, 0, 0, 0, 1, 0);
    check_eq("t6_sleeping", entry_v_o, 2'b01);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    #1;
    check_eq("t6_entry_v", entry_v_o, 0);
    check_eq("t6_resp_v", lce_resp_v_o, 0);
    check_eq("t6_req_v", lce_req_v_o, 0);
    step();
    check_eq("t6_still_no_ack", lce_resp_v_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
